// File: rtl/instr_mem_sync_if.sv
// instr_mem_sync_if: fetch request/response and load-port signals for the
// instruction memory. The master drives requests and loads; the slave is the
// memory itself.
interface instr_mem_sync_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  ld_be;

    modport master (
        output req_valid, req_pc, rsp_ready, ld_valid, ld_addr, ld_data, ld_be,
        input  req_ready, rsp_valid, rsp_instr, rsp_err, ld_ready
    );

    modport slave (
        input  req_valid, req_pc, rsp_ready, ld_valid, ld_addr, ld_data, ld_be,
        output req_ready, rsp_valid, rsp_instr, rsp_err, ld_ready
    );
endinterface

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous, writable instruction memory with a
// valid/ready fetch port (one-cycle read latency, registered response) and a
// byte-enabled load port. Loads take priority over fetches.
// Optional boot sweep that fills every word with NOP_WORD after reset:
// define IMEM_BOOT_CLEAR_EN to build it in.
module instr_mem_sync #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    instr_mem_sync_if.slave bus,
    output logic            busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state_q, state_d;
    logic [31:0]           mem [DEPTH];
    logic                  run;
    logic                  ld_fire;
    logic                  req_fire;
    logic                  fetch_err;
    logic [DEPTH_LOG2-1:0] fetch_idx;
    logic [DEPTH_LOG2-1:0] ld_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [31:0]           wr_data;
    logic [3:0]            wr_be;
    logic                  unused_ld_bits;

    assign run           = (state_q == RUN);
    assign bus.ld_ready  = run;
    assign bus.req_ready = run && !bus.ld_valid && (!bus.rsp_valid || bus.rsp_ready);
    assign ld_fire       = bus.ld_valid && bus.ld_ready;
    assign req_fire      = bus.req_valid && bus.req_ready;

    assign fetch_idx = bus.req_pc[DEPTH_LOG2+1:2];
    assign fetch_err = (bus.req_pc[1:0] != 2'b00) || (bus.req_pc[31:DEPTH_LOG2+2] != '0);

    // Load addresses only select a word; the byte offset and the bits above
    // the array are ignored.
    assign ld_idx         = bus.ld_addr[DEPTH_LOG2+1:2];
    assign unused_ld_bits = ^{bus.ld_addr[31:DEPTH_LOG2+2], bus.ld_addr[1:0]};

`ifdef IMEM_BOOT_CLEAR_EN
    logic [DEPTH_LOG2-1:0] cnt_q;

    // State and sweep counter; every reset restarts the sweep from word 0.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) cnt_q <= cnt_q + DEPTH_LOG2'(1);
        end
    end

    // Leave CLEAR once the last word has been written.
    always_comb begin
        // NOTE: the default comes first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        if (state_q == CLEAR && (&cnt_q)) state_d = RUN;
    end

    assign busy = (state_q == CLEAR);
`else
    // Without the sweep the FSM comes out of reset directly in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    // RUN is terminal.
    always_comb begin
        state_d = state_q;
    end

    assign busy = 1'b0;
`endif

    // Select the single write source: the boot sweep when present, else the load port.
    always_comb begin
        wr_idx  = ld_idx;
        wr_data = bus.ld_data;
        wr_be   = ld_fire ? bus.ld_be : 4'b0000;
`ifdef IMEM_BOOT_CLEAR_EN
        if (state_q == CLEAR) begin
            wr_idx  = cnt_q;
            wr_data = NOP_WORD;
            wr_be   = 4'b1111;
        end
`endif
    end

    // Byte-lane write into the storage array.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto block RAM; contents are
        // defined only by the sweep or by loads.
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    // Response register: capture on an accepted fetch, hold under backpressure,
    // drop valid once consumed with no new fetch behind it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_instr <= NOP_WORD;
            bus.rsp_err   <= 1'b0;
        end else if (req_fire) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= fetch_err;
            bus.rsp_instr <= fetch_err ? NOP_WORD : mem[fetch_idx];
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule
